vga_frame_reader: RTL and testbench



---
 rtl/vga_frame_reader_if.sv | 28 ++
 rtl/vga_frame_reader.sv | 127 ++++++++++++
 tb/tb_vga_frame_reader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_frame_reader_if.sv
// VGA scan-out bundle between the frame reader, the display buffer and the DAC.
// master drives addresses, colour and sync; slave returns buffer pixels on vga_din.
interface vga_frame_reader_if;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_din;
    logic       vga_r;
    logic       vga_g;
    logic       vga_b;
    logic       vga_hs;
    logic       vga_vs;
    logic       vga_blank_n;
    logic       frame_start;

    modport master (
        output vga_x, vga_y,
        input  vga_din,
        output vga_r, vga_g, vga_b,
        output vga_hs, vga_vs, vga_blank_n, frame_start
    );

    modport slave (
        input  vga_x, vga_y,
        output vga_din,
        input  vga_r, vga_g, vga_b,
        input  vga_hs, vga_vs, vga_blank_n, frame_start
    );
endinterface

// File: rtl/vga_frame_reader.sv
// 640x480@60 scan-out engine reading a 160x120x3 buffer with 4x4 upscaling.
// Ports: clk, rst (sync, active high), vga (master): buffer address out,
// buffer pixel in, registered rgb/hs/vs/blank_n/frame_start out.
module vga_frame_reader #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SCALE_SHIFT = 2,
    parameter int RD_LAT      = 2
) (
    input  logic               clk,
    input  logic               rst,
    vga_frame_reader_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] hc;
    logic [VW-1:0] vc;
    logic [HW-1:0] hc_sc;
    logic [VW-1:0] vc_sc;

    logic act;
    logic hs_raw;
    logic vs_raw;
    logic fs_raw;

    logic [7:0] x_q;
    logic [6:0] y_q;
    logic [2:0] rgb_q;

    // Stage i holds the raw timing of the counter value i+1 clocks ago.
    logic [RD_LAT:0] act_q;
    logic [RD_LAT:0] hs_q;
    logic [RD_LAT:0] vs_q;
    logic [RD_LAT:0] fs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + VW'(1);
        end else begin
            hc <= hc + HW'(1);
        end
    end

    assign act    = (hc < H_VIS) && (vc < V_VIS);
    assign hs_raw = !((hc >= HS_BEG) && (hc < HS_END));
    assign vs_raw = !((vc >= VS_BEG) && (vc < VS_END));
    assign fs_raw = (hc == '0) && (vc == '0);

    assign hc_sc = hc >> SCALE_SHIFT;
    assign vc_sc = vc >> SCALE_SHIFT;

    // Addresses are parked at 0 during blanking so the buffer sees a
    // fixed, in-range address outside the visible area.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (act) begin
            x_q <= 8'(hc_sc);
            y_q <= 7'(vc_sc);
        end else begin
            x_q <= '0;
            y_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q <= '0;
            hs_q  <= '1;
            vs_q  <= '1;
            fs_q  <= '0;
        end else begin
            act_q <= {act_q[RD_LAT-1:0], act};
            hs_q  <= {hs_q[RD_LAT-1:0], hs_raw};
            vs_q  <= {vs_q[RD_LAT-1:0], vs_raw};
            fs_q  <= {fs_q[RD_LAT-1:0], fs_raw};
        end
    end

    // RD_LAT counts from the counter through the address register to
    // vga_din, so the pixel on vga_din now belongs to the counter value
    // RD_LAT clocks ago; gate it with that stage's active flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= '0;
        end else if (act_q[RD_LAT-1]) begin
            rgb_q <= vga.vga_din;
        end else begin
            rgb_q <= '0;
        end
    end

    assign vga.vga_x       = x_q;
    assign vga.vga_y       = y_q;
    assign vga.vga_r       = rgb_q[2];
    assign vga.vga_g       = rgb_q[1];
    assign vga.vga_b       = rgb_q[0];
    assign vga.vga_blank_n = act_q[RD_LAT];
    assign vga.vga_hs      = hs_q[RD_LAT];
    assign vga.vga_vs      = vs_q[RD_LAT];
    assign vga.frame_start = fs_q[RD_LAT];

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader: a reduced-geometry instance for
// full-frame checks and a default 640x480 instance for line-level checks.
module tb_vga_frame_reader;

    typedef struct {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
    } tim_t;

    localparam tim_t TS = '{32, 4, 6, 6, 16, 2, 2, 3};
    localparam tim_t TD = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam int HTS = 48;
    localparam int VTS = 23;
    localparam int FTS = HTS * VTS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   k = 0;

    logic       mode = 1'b1;
    logic [2:0] cval = 3'b111;
    logic       mode_p = 1'b1;
    logic [2:0] cval_p = 3'b111;
    logic [2:0] dreg_s = '0;
    logic [2:0] dreg_d = '0;

    vga_frame_reader_if ifs ();
    vga_frame_reader_if ifd ();

    vga_frame_reader #(
        .H_ACTIVE(32), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SCALE_SHIFT(2), .RD_LAT(2)
    ) dut_s (
        .clk(clk),
        .rst(rst),
        .vga(ifs.master)
    );

    vga_frame_reader dut_d (
        .clk(clk),
        .rst(rst),
        .vga(ifd.master)
    );

    always #5 clk = ~clk;

    // Buffer model: one register after the DUT's address register gives
    // the two-clock counter-to-pixel path; pixel = (x+y) mod 8.
    always @(posedge clk) begin
        dreg_s <= 3'(ifs.vga_x + 8'(ifs.vga_y));
        dreg_d <= 3'(ifd.vga_x + 8'(ifd.vga_y));
        mode_p <= mode;
        cval_p <= cval;
        k      <= rst ? 0 : k + 1;
    end

    assign ifs.vga_din = mode ? cval : dreg_s;
    assign ifd.vga_din = mode ? cval : dreg_d;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic pos(input tim_t t, input int n, output int hc,
                       output int vc, output logic act, output logic hs,
                       output logic vs, output logic fs);
        int ht;
        int vt;
        ht  = t.ha + t.hf + t.hs + t.hb;
        vt  = t.va + t.vf + t.vs + t.vb;
        hc  = n % ht;
        vc  = (n / ht) % vt;
        act = (hc < t.ha) && (vc < t.va);
        hs  = !((hc >= t.ha + t.hf) && (hc < t.ha + t.hf + t.hs));
        vs  = !((vc >= t.va + t.vf) && (vc < t.va + t.vf + t.vs));
        fs  = (hc == 0) && (vc == 0);
    endtask

    // Expected outputs for cycle k are those of counter value k-3;
    // expected address is that of counter value k-1.
    task automatic check_dut(input string nm, input tim_t t,
                             input logic [7:0] x, input logic [6:0] y,
                             input logic [2:0] rgb, input logic hs,
                             input logic vs, input logic bl,
                             input logic fs);
        int hc, vc;
        logic a, h, v, f;
        logic [2:0] ec;
        int ex, ey;
        a = 1'b0; h = 1'b1; v = 1'b1; f = 1'b0; ec = '0;
        if (k >= 3) begin
            pos(t, k - 3, hc, vc, a, h, v, f);
            if (a)
                ec = mode_p ? cval_p : 3'((hc >> 2) + (vc >> 2));
        end
        ex = 0;
        ey = 0;
        if (k >= 1) begin
            pos(t, k - 1, hc, vc, a, h, v, f);
            if (a) begin
                ex = hc >> 2;
                ey = vc >> 2;
            end
            if (k >= 3) pos(t, k - 3, hc, vc, a, h, v, f);
            else begin
                a = 1'b0; h = 1'b1; v = 1'b1; f = 1'b0;
            end
        end
        chk({nm, ".x"}, 32'(x), 32'(ex));
        chk({nm, ".y"}, 32'(y), 32'(ey));
        chk({nm, ".rgb"}, 32'(rgb), 32'(ec));
        chk({nm, ".hs"}, 32'(hs), 32'(h));
        chk({nm, ".vs"}, 32'(vs), 32'(v));
        chk({nm, ".blank_n"}, 32'(bl), 32'(a));
        chk({nm, ".frame_start"}, 32'(fs), 32'(f));
    endtask

    task automatic tick();
        @(negedge clk);
        check_dut("s", TS, ifs.vga_x, ifs.vga_y,
                  {ifs.vga_r, ifs.vga_g, ifs.vga_b},
                  ifs.vga_hs, ifs.vga_vs, ifs.vga_blank_n,
                  ifs.frame_start);
        check_dut("d", TD, ifd.vga_x, ifd.vga_y,
                  {ifd.vga_r, ifd.vga_g, ifd.vga_b},
                  ifd.vga_hs, ifd.vga_vs, ifd.vga_blank_n,
                  ifd.frame_start);
    endtask

    initial begin
        int n_hs, n_vs, n_bl, n_fs, fs1, fs2;
        int d_hs, d_hs_first, d_bl, d_x159;
        int n_rgb7, n_bad;

        // Reset held with an all-ones buffer pixel.
        rst  = 1'b1;
        mode = 1'b1;
        cval = 3'b111;
        for (int i = 0; i < 5; i++) tick();

        // Release into the (x+y) pattern; run two small frames.
        mode = 1'b0;
        rst  = 1'b0;
        n_hs = 0; n_vs = 0; n_bl = 0; n_fs = 0; fs1 = -1; fs2 = -1;
        d_hs = 0; d_hs_first = -1; d_bl = 0; d_x159 = 0;
        for (int i = 1; i <= 2 * FTS + 3; i++) begin
            tick();
            if (i >= 3 && i < 3 + 2 * FTS) begin
                n_hs += int'(!ifs.vga_hs);
                n_vs += int'(!ifs.vga_vs);
                n_bl += int'(ifs.vga_blank_n);
            end
            if (ifs.frame_start) begin
                n_fs++;
                if (fs1 < 0) fs1 = i;
                else if (fs2 < 0) fs2 = i;
            end
            if (i >= 3 && i < 803) begin
                d_hs += int'(!ifd.vga_hs);
                d_bl += int'(ifd.vga_blank_n);
                if (!ifd.vga_hs && d_hs_first < 0) d_hs_first = i;
            end
            if (i <= 800 && ifd.vga_x == 8'd159) d_x159++;
        end
        chk("first_fs", 32'(fs1), 32'd3);
        chk("fs_period", 32'(fs2 - fs1), 32'(FTS));
        chk("fs_count", 32'(n_fs), 32'd3);
        chk("hs_low_total", 32'(n_hs), 32'(2 * VTS * 6));
        chk("vs_low_total", 32'(n_vs), 32'(2 * 2 * HTS));
        chk("blank_total", 32'(n_bl), 32'(2 * 16 * 32));
        chk("d_hs_low", 32'(d_hs), 32'd96);
        chk("d_hs_start", 32'(d_hs_first), 32'(3 + 656));
        chk("d_blank_line", 32'(d_bl), 32'd640);
        chk("d_x159_count", 32'(d_x159), 32'd4);

        // Mid-frame reset with an all-ones pixel driven throughout.
        for (int i = 0; i < 300; i++) tick();
        mode = 1'b1;
        cval = 3'b111;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b0;
        n_rgb7 = 0;
        for (int i = 1; i <= FTS + 3; i++) begin
            tick();
            if (i >= 3 && i < 3 + FTS)
                n_rgb7 += int'({ifs.vga_r, ifs.vga_g, ifs.vga_b} == 3'b111);
        end
        chk("rgb7_frame", 32'(n_rgb7), 32'(16 * 32));

        // Channel mapping: each single-bit pixel reaches only its channel.
        cval = 3'b100;
        n_bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            n_bad += int'(ifs.vga_g | ifs.vga_b);
        end
        chk("only_r", 32'(n_bad), 32'd0);
        cval = 3'b010;
        n_bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i >= 2) n_bad += int'(ifs.vga_r | ifs.vga_b);
        end
        chk("only_g", 32'(n_bad), 32'd0);
        cval = 3'b001;
        n_bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i >= 2) n_bad += int'(ifs.vga_r | ifs.vga_g);
        end
        chk("only_b", 32'(n_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
